// File: rtl/pc_fetch_pkg.sv
// rtl/pc_fetch_pkg.sv - shared types and constants for the fetch stage
//
// Purpose : next-PC select encoding, NOP word and default reset PC used by
//           pc_fetch and pc_next.
// Contents: pcsrc_e, NOP_INSTR, RESET_PC.
package fetch_pkg;

  typedef enum logic [1:0] {
    PC_SEQ  = 2'b00,
    PC_BR   = 2'b01,
    PC_JALR = 2'b10,
    PC_RSVD = 2'b11
  } pcsrc_e;

  // addi x0,x0,0
  localparam logic [31:0] NOP_INSTR = 32'h0000_0013;
  localparam logic [31:0] RESET_PC  = 32'h0000_0000;

endpackage

// File: rtl/pc_fetch_if.sv
// rtl/pc_fetch_if.sv - instruction memory read bus between fetch and imem
//
// Purpose : carries the fetch address and the combinationally returned word.
// Ports   : PC (fetch -> memory address A), RD (memory -> fetch word).
// Modports: master = fetch stage, slave = instruction memory.
interface pc_fetch_if #(
  parameter int ADDRESS_WIDTH = 32,
  parameter int INSTR_WIDTH   = 32
);

  logic [ADDRESS_WIDTH-1:0] PC;
  logic [INSTR_WIDTH-1:0]   RD;

  modport master (output PC, input RD);
  modport slave  (input PC, output RD);

endinterface

// File: rtl/pc_fetch_pc_next.sv
// rtl/pc_fetch_pc_next.sv - next-PC mux, redirect target alignment, misalign detect
//
// Purpose : purely combinational; picks sequential or redirect target and
//           forces the target to word alignment.
// Ports   : PCsrc, pc, pc_d, ImmOp, jalr_target (in);
//           pc_plus4, target, redirect, misalign (out).
module pc_next
  import fetch_pkg::*;
#(
  parameter int ADDRESS_WIDTH = 32
) (
  input  logic [1:0]               PCsrc,
  input  logic [ADDRESS_WIDTH-1:0] pc,
  input  logic [ADDRESS_WIDTH-1:0] pc_d,
  input  logic [ADDRESS_WIDTH-1:0] ImmOp,
  input  logic [ADDRESS_WIDTH-1:0] jalr_target,
  output logic [ADDRESS_WIDTH-1:0] pc_plus4,
  output logic [ADDRESS_WIDTH-1:0] target,
  output logic                     redirect,
  output logic                     misalign
);

  logic [ADDRESS_WIDTH-1:0] raw_target;

  assign pc_plus4 = pc + ADDRESS_WIDTH'(4);

  always_comb begin
    raw_target = pc_plus4;
    redirect   = 1'b0;
    case (pcsrc_e'(PCsrc))
      // Branch/JAL is relative to the instruction sitting in decode.
      PC_BR: begin
        raw_target = pc_d + ImmOp;
        redirect   = 1'b1;
      end
      // JALR clears bit 0 first, so only bit 1 can flag misalignment.
      PC_JALR: begin
        raw_target = jalr_target & ~ADDRESS_WIDTH'(1);
        redirect   = 1'b1;
      end
      default: begin
        raw_target = pc_plus4;
        redirect   = 1'b0;
      end
    endcase
  end

  assign target   = {raw_target[ADDRESS_WIDTH-1:2], 2'b00};
  assign misalign = redirect && (raw_target[1:0] != 2'b00);

endmodule

// File: rtl/pc_fetch.sv
// rtl/pc_fetch.sv - instruction fetch stage: PC register and fetch/decode register
//
// Purpose : drives the instruction memory address, selects the next PC and
//           captures the returned word with stall, flush and redirect squash.
// Ports   : clk, rst (async, active-high); en, flush, PCsrc, ImmOp,
//           jalr_target (control in); imem (PC out / RD in);
//           instr_d, pc_d, pc_plus4_d, valid_d, misalign (decode outputs).
module pc_fetch
  import fetch_pkg::*;
#(
  parameter int                       ADDRESS_WIDTH = 32,
  parameter int                       INSTR_WIDTH   = 32,
  parameter logic [ADDRESS_WIDTH-1:0] RESET_PC      = fetch_pkg::RESET_PC
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     en,
  input  logic                     flush,
  input  logic [1:0]               PCsrc,
  input  logic [ADDRESS_WIDTH-1:0] ImmOp,
  input  logic [ADDRESS_WIDTH-1:0] jalr_target,
  pc_fetch_if.master               imem,
  output logic [INSTR_WIDTH-1:0]   instr_d,
  output logic [ADDRESS_WIDTH-1:0] pc_d,
  output logic [ADDRESS_WIDTH-1:0] pc_plus4_d,
  output logic                     valid_d,
  output logic                     misalign
);

  localparam logic [INSTR_WIDTH-1:0] NOP = INSTR_WIDTH'(NOP_INSTR);

  logic [ADDRESS_WIDTH-1:0] pc_q;
  logic [ADDRESS_WIDTH-1:0] pc_plus4;
  logic [ADDRESS_WIDTH-1:0] target;
  logic                     redirect;
  logic                     target_misalign;

  assign imem.PC = pc_q;

  pc_next #(
    .ADDRESS_WIDTH(ADDRESS_WIDTH)
  ) u_pc_next (
    .PCsrc      (PCsrc),
    .pc         (pc_q),
    .pc_d       (pc_d),
    .ImmOp      (ImmOp),
    .jalr_target(jalr_target),
    .pc_plus4   (pc_plus4),
    .target     (target),
    .redirect   (redirect),
    .misalign   (target_misalign)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pc_q       <= RESET_PC;
      instr_d    <= NOP;
      valid_d    <= 1'b0;
      pc_d       <= RESET_PC;
      pc_plus4_d <= RESET_PC + ADDRESS_WIDTH'(4);
      misalign   <= 1'b0;
    end else if (!en) begin
      // Stall: everything holds except that a flush still kills decode.
      misalign <= 1'b0;
      if (flush) begin
        instr_d <= NOP;
        valid_d <= 1'b0;
      end
    end else if (redirect) begin
      // The word fetched at the old PC is wrong-path and is squashed.
      pc_q       <= target;
      instr_d    <= NOP;
      valid_d    <= 1'b0;
      pc_d       <= pc_q;
      pc_plus4_d <= pc_plus4;
      misalign   <= target_misalign;
    end else begin
      pc_q       <= pc_plus4;
      instr_d    <= flush ? NOP : imem.RD;
      valid_d    <= ~flush;
      pc_d       <= pc_q;
      pc_plus4_d <= pc_plus4;
      misalign   <= 1'b0;
    end
  end

endmodule

// File: tb/tb_pc_fetch.sv
// tb/tb_pc_fetch.sv - directed self-checking bench for pc_fetch
module tb_pc_fetch;

  logic        clk = 1'b0;
  logic        rst;
  logic        en;
  logic        flush;
  logic [1:0]  PCsrc;
  logic [31:0] ImmOp;
  logic [31:0] jalr_target;

  logic [31:0] instr_a, pc_d_a, pc4_a;
  logic        valid_a, mis_a;
  logic [31:0] instr_b, pc_d_b, pc4_b;
  logic        valid_b, mis_b;

  int n_cmp = 0;
  int n_bad = 0;

  pc_fetch_if #(.ADDRESS_WIDTH(32), .INSTR_WIDTH(32)) if_a ();
  pc_fetch_if #(.ADDRESS_WIDTH(32), .INSTR_WIDTH(32)) if_b ();

  // Memory image: word at address X reads as C0DE_xxxx with xxxx = X[15:0].
  assign if_a.RD = 32'hC0DE_0000 | {16'h0000, if_a.PC[15:0]};
  assign if_b.RD = 32'hC0DE_0000 | {16'h0000, if_b.PC[15:0]};

  pc_fetch #(.ADDRESS_WIDTH(32), .INSTR_WIDTH(32), .RESET_PC(32'h0000_0000)) dut_a (
    .clk(clk), .rst(rst), .en(en), .flush(flush), .PCsrc(PCsrc), .ImmOp(ImmOp),
    .jalr_target(jalr_target), .imem(if_a), .instr_d(instr_a), .pc_d(pc_d_a),
    .pc_plus4_d(pc4_a), .valid_d(valid_a), .misalign(mis_a)
  );

  pc_fetch #(.ADDRESS_WIDTH(32), .INSTR_WIDTH(32), .RESET_PC(32'hFFFF_FFF8)) dut_b (
    .clk(clk), .rst(rst), .en(en), .flush(flush), .PCsrc(PCsrc), .ImmOp(ImmOp),
    .jalr_target(jalr_target), .imem(if_b), .instr_d(instr_b), .pc_d(pc_d_b),
    .pc_plus4_d(pc4_b), .valid_d(valid_b), .misalign(mis_b)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp)
    else begin
      n_bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst = 1'b1; en = 1'b0; flush = 1'b0; PCsrc = 2'b00;
    ImmOp = 32'h0; jalr_target = 32'h0;
    #2;
    chk("rst_pc", if_a.PC, 32'h0);
    chk("rst_instr", instr_a, 32'h0000_0013);
    chk("rst_valid", {31'b0, valid_a}, 32'h0);
    chk("rst_pc_d", pc_d_a, 32'h0);
    chk("rst_pc4", pc4_a, 32'h4);
    chk("rst_mis", {31'b0, mis_a}, 32'h0);
    chk("rst_b_pc", if_b.PC, 32'hFFFF_FFF8);
    chk("rst_b_pc4", pc4_b, 32'hFFFF_FFFC);

    #10;
    rst = 1'b0; en = 1'b1;

    // Sequential run
    step();
    chk("seq1_pc", if_a.PC, 32'h4);
    chk("seq1_instr", instr_a, 32'hC0DE_0000);
    chk("seq1_pc_d", pc_d_a, 32'h0);
    chk("seq1_valid", {31'b0, valid_a}, 32'h1);
    chk("wrap1_b_pc", if_b.PC, 32'hFFFF_FFFC);
    step();
    chk("seq2_pc", if_a.PC, 32'h8);
    chk("seq2_instr", instr_a, 32'hC0DE_0004);
    chk("seq2_pc_d", pc_d_a, 32'h4);
    chk("wrap2_b_pc", if_b.PC, 32'h0);
    step();
    chk("seq3_pc", if_a.PC, 32'hC);
    chk("seq3_instr", instr_a, 32'hC0DE_0008);
    chk("seq3_pc4", pc4_a, 32'hC);
    chk("wrap3_b_pc", if_b.PC, 32'h4);
    step();
    chk("seq4_pc", if_a.PC, 32'h10);
    chk("seq4_instr", instr_a, 32'hC0DE_000C);
    chk("seq4_pc_d", pc_d_a, 32'hC);
    step();
    chk("seq5_pc_d", pc_d_a, 32'h10);
    chk("seq5_pc", if_a.PC, 32'h14);

    // Branch relative to pc_d=0x10, imm=-8
    PCsrc = 2'b01; ImmOp = 32'hFFFF_FFF8;
    step();
    chk("br_pc", if_a.PC, 32'h8);
    chk("br_valid", {31'b0, valid_a}, 32'h0);
    chk("br_instr", instr_a, 32'h0000_0013);
    chk("br_pc_d", pc_d_a, 32'h14);
    chk("br_mis", {31'b0, mis_a}, 32'h0);
    PCsrc = 2'b00;
    step();
    chk("br_after_pc", if_a.PC, 32'hC);
    chk("br_after_instr", instr_a, 32'hC0DE_0008);
    chk("br_after_valid", {31'b0, valid_a}, 32'h1);

    // JALR to 0x103: bit 1 stays set after the mask -> misaligned
    PCsrc = 2'b10; jalr_target = 32'h0000_0103;
    step();
    chk("jalr1_pc", if_a.PC, 32'h100);
    chk("jalr1_mis", {31'b0, mis_a}, 32'h1);
    chk("jalr1_valid", {31'b0, valid_a}, 32'h0);
    PCsrc = 2'b00;
    step();
    chk("jalr1_mis_end", {31'b0, mis_a}, 32'h0);
    chk("jalr1_next_pc", if_a.PC, 32'h104);
    chk("jalr1_instr", instr_a, 32'hC0DE_0100);
    chk("jalr1_pc4", pc4_a, 32'h104);

    // JALR to 0x101: mask clears bit 0, no misalign
    PCsrc = 2'b10; jalr_target = 32'h0000_0101;
    step();
    chk("jalr2_pc", if_a.PC, 32'h100);
    chk("jalr2_mis", {31'b0, mis_a}, 32'h0);
    PCsrc = 2'b00;
    step();
    chk("jalr2_next_pc", if_a.PC, 32'h104);
    chk("jalr2_instr", instr_a, 32'hC0DE_0100);

    // Stall with PCsrc toggling
    en = 1'b0;
    PCsrc = 2'b01; step();
    PCsrc = 2'b10; step();
    PCsrc = 2'b01; step();
    chk("stall_pc", if_a.PC, 32'h104);
    chk("stall_instr", instr_a, 32'hC0DE_0100);
    chk("stall_valid", {31'b0, valid_a}, 32'h1);
    flush = 1'b1;
    step();
    chk("stflush_valid", {31'b0, valid_a}, 32'h0);
    chk("stflush_instr", instr_a, 32'h0000_0013);
    chk("stflush_pc", if_a.PC, 32'h104);
    chk("stflush_pc_d", pc_d_a, 32'h100);
    flush = 1'b0; en = 1'b1; PCsrc = 2'b00;
    step();
    chk("resume_pc", if_a.PC, 32'h108);
    chk("resume_instr", instr_a, 32'hC0DE_0104);
    chk("resume_valid", {31'b0, valid_a}, 32'h1);

    // Redirect with flush, then back-to-back redirect from the new pc_d
    PCsrc = 2'b01; ImmOp = 32'h20; flush = 1'b1;
    step();
    chk("brfl_pc", if_a.PC, 32'h124);
    chk("brfl_valid", {31'b0, valid_a}, 32'h0);
    flush = 1'b0; ImmOp = 32'h4;
    step();
    chk("b2b_pc", if_a.PC, 32'h10C);
    chk("b2b_pc_d", pc_d_a, 32'h124);
    chk("b2b_valid", {31'b0, valid_a}, 32'h0);

    // Sequential flush
    PCsrc = 2'b00; flush = 1'b1;
    step();
    chk("sqfl_pc", if_a.PC, 32'h110);
    chk("sqfl_instr", instr_a, 32'h0000_0013);
    chk("sqfl_valid", {31'b0, valid_a}, 32'h0);
    flush = 1'b0;
    step();
    chk("sqfl_after_valid", {31'b0, valid_a}, 32'h1);

    // Async reset mid-cycle during a misaligned redirect request
    PCsrc = 2'b01; ImmOp = 32'h42;
    step();
    chk("pre_rst_mis", {31'b0, mis_a}, 32'h1);
    #3;
    rst = 1'b1;
    #1;
    chk("arst_pc", if_a.PC, 32'h0);
    chk("arst_instr", instr_a, 32'h0000_0013);
    chk("arst_valid", {31'b0, valid_a}, 32'h0);
    chk("arst_pc_d", pc_d_a, 32'h0);
    chk("arst_pc4", pc4_a, 32'h4);
    chk("arst_mis", {31'b0, mis_a}, 32'h0);
    #1;
    rst = 1'b0; PCsrc = 2'b00;
    step();
    chk("post_rst_pc", if_a.PC, 32'h4);
    chk("post_rst_instr", instr_a, 32'hC0DE_0000);
    chk("post_rst_valid", {31'b0, valid_a}, 32'h1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
